// File: rtl/pipeline_stall_control_if.sv
// Pipeline stall/multdiv control bundle: F/D and D/X instructions,
// multdiv handshake in, stall/bubble/writeback controls out.
interface pipeline_stall_control_if;
  logic [31:0] FDIR;
  logic [31:0] DXIR;
  logic        mdRDY;
  logic        mdExcIn;
  logic        stallPC;
  logic        stallFD;
  logic        holdDX;
  logic        bubbleDX;
  logic        ctrlMult;
  logic        ctrlDiv;
  logic        mdWriteback;
  logic        mdExc;
  logic        mdTimeout;

  modport master (
    output FDIR, DXIR, mdRDY, mdExcIn,
    input  stallPC, stallFD, holdDX, bubbleDX,
    input  ctrlMult, ctrlDiv,
    input  mdWriteback, mdExc, mdTimeout
  );

  modport slave (
    input  FDIR, DXIR, mdRDY, mdExcIn,
    output stallPC, stallFD, holdDX, bubbleDX,
    output ctrlMult, ctrlDiv,
    output mdWriteback, mdExc, mdTimeout
  );
endinterface

// File: rtl/pipeline_stall_control.sv
// Load-use and multdiv stall control with IDLE/BUSY/DONE sequencer.
// Define MULTDIV_TIMEOUT_EN to enable the multdiv watchdog.
module pipeline_stall_control #(
  parameter int MD_MAX_CYCLES = 40
) (
  input  logic                          clock,
  input  logic                          reset,
  pipeline_stall_control_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [5:0] LP_LIMIT =
    6'(MD_MAX_CYCLES - 1);

  state_t     r_state;
  logic [5:0] r_cnt;
  logic       r_exc;
  logic       r_tmo;

  logic [4:0] w_dx_op;
  logic [4:0] w_dx_rd;
  logic [4:0] w_dx_alu;
  logic [4:0] w_fd_op;
  logic [4:0] w_fd_rd;
  logic [4:0] w_fd_rs;
  logic [4:0] w_fd_rt;
  logic       w_is_mult;
  logic       w_is_div;
  logic       w_is_md;
  logic       w_rd_rs;
  logic       w_rd_rt;
  logic       w_rd_rd;
  logic       w_hazard;
  logic       w_idle;
  logic       w_md_stall;
  logic       w_lu_stall;

  assign w_dx_op  = bus.DXIR[31:27];
  assign w_dx_rd  = bus.DXIR[26:22];
  assign w_dx_alu = bus.DXIR[6:2];
  assign w_fd_op  = bus.FDIR[31:27];
  assign w_fd_rd  = bus.FDIR[26:22];
  assign w_fd_rs  = bus.FDIR[21:17];
  assign w_fd_rt  = bus.FDIR[16:12];

  assign w_is_mult = (w_dx_op == 5'd0) &&
                     (w_dx_alu == 5'd6);
  assign w_is_div  = (w_dx_op == 5'd0) &&
                     (w_dx_alu == 5'd7);
  assign w_is_md   = w_is_mult || w_is_div;

  // Which F/D fields are actual source reads
  assign w_rd_rs = (w_fd_op == 5'd0) ||
                   (w_fd_op == 5'd2) ||
                   (w_fd_op == 5'd5) ||
                   (w_fd_op == 5'd6) ||
                   (w_fd_op == 5'd7) ||
                   (w_fd_op == 5'd8);
  assign w_rd_rt = (w_fd_op == 5'd0);
  assign w_rd_rd = (w_fd_op == 5'd2) ||
                   (w_fd_op == 5'd4) ||
                   (w_fd_op == 5'd6) ||
                   (w_fd_op == 5'd7);

  assign w_hazard =
    (w_dx_op == 5'd8) && (w_dx_rd != 5'd0) &&
    ((w_rd_rs && (w_fd_rs == w_dx_rd)) ||
     (w_rd_rt && (w_fd_rt == w_dx_rd)) ||
     (w_rd_rd && (w_fd_rd == w_dx_rd)));

  assign w_idle = (r_state == IDLE);

  assign w_md_stall = !reset &&
    ((w_idle && w_is_md) || (r_state == BUSY));
  assign w_lu_stall = !reset && w_idle &&
    !w_is_md && w_hazard;

  assign bus.stallPC  = w_md_stall || w_lu_stall;
  assign bus.stallFD  = w_md_stall || w_lu_stall;
  assign bus.holdDX   = w_md_stall;
  assign bus.bubbleDX = w_lu_stall;
  assign bus.ctrlMult = !reset && w_idle && w_is_mult;
  assign bus.ctrlDiv  = !reset && w_idle && w_is_div;

  assign bus.mdWriteback = (r_state == DONE);
  assign bus.mdExc       = (r_state == DONE) && r_exc;

`ifdef MULTDIV_TIMEOUT_EN
  logic w_expired;
  logic w_unused;
  assign w_expired = (r_cnt == LP_LIMIT);
  assign bus.mdTimeout = (r_state == DONE) && r_tmo;
  assign w_unused = ^{bus.DXIR[21:7], bus.DXIR[1:0],
                      bus.FDIR[11:0]};
`else
  logic w_expired;
  logic w_unused;
  assign w_expired = 1'b0;
  assign bus.mdTimeout = 1'b0;
  assign w_unused = ^{bus.DXIR[21:7], bus.DXIR[1:0],
                      bus.FDIR[11:0], r_cnt, r_tmo,
                      LP_LIMIT};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
      r_exc   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_is_md) begin
            r_state <= BUSY;
            r_cnt   <= 6'd0;
            r_exc   <= 1'b0;
            r_tmo   <= 1'b0;
          end
        end
        BUSY: begin
          if (r_cnt != 6'd63)
            r_cnt <= r_cnt + 6'd1;
          // A ready strobe beats the watchdog
          if (bus.mdRDY) begin
            r_state <= DONE;
            r_exc   <= bus.mdExcIn;
            r_tmo   <= 1'b0;
          end else if (w_expired) begin
            r_state <= DONE;
            r_exc   <= 1'b1;
            r_tmo   <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
